fifo_asym_n2w: RTL

- Synchronous FIFO that accepts narrow DWIDTH-bit words and delivers them in pairs as 2*DWIDTH-bit words. It is the companion of the wide-write/narrow-read asymmetric FIFO in the other direction.
- Typical use: gathering byte streams, such as UART receive or packet bytes, into halfword-wide datapaths.
- Byte order: the first byte written lands in the low half of the output word, so a wide-to-narrow FIFO followed by this block is an identity path.
- Read side is first-word-fall-through: the head word is visible on dout before r_en is asserted.

---
 rtl/fifo_asym_n2w.sv | 71 +++++++
 1 files changed

// File: rtl/fifo_asym_n2w.sv
// fifo_asym_n2w: narrow-write / wide-read FIFO that pairs DWIDTH-bit words into 2*DWIDTH-bit words.
// Optional macro FIFO_ASYM_N2W_CNT_EN adds the count and almost_full outputs.
module fifo_asym_n2w #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [DWIDTH-1:0]   din,
    input  logic                w_en,
    output logic [2*DWIDTH-1:0] dout,
    input  logic                r_en,
    output logic                full,
    output logic                empty,
`ifdef FIFO_ASYM_N2W_CNT_EN
    output logic [AWIDTH:0]     count,
    output logic                almost_full,
`endif
    output logic                pending
);
    localparam logic [AWIDTH:0] CAP = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] TWO = {{(AWIDTH-1){1'b0}}, 2'b10};

    logic [DWIDTH-1:0] mem [2**AWIDTH];
    logic [AWIDTH:0]   wp_q, wp_d;
    logic [AWIDTH-1:0] rp_q, rp_d;
    logic [AWIDTH:0]   cnt_q, cnt_d;
    logic              we, re;
    logic              unused_wrap;

    // Flags, acceptance, next pointers and occupancy; flags come only from the count
    always_comb begin
        full    = (cnt_q == CAP);
        empty   = (cnt_q < TWO);
        pending = cnt_q[0];
        we      = w_en && !full;
        re      = r_en && !empty;
        wp_d    = wp_q + {{AWIDTH{1'b0}}, we};
        rp_d    = rp_q + {{(AWIDTH-1){1'b0}}, re};
        cnt_d   = cnt_q + {{AWIDTH{1'b0}}, we} - {{(AWIDTH-1){1'b0}}, re, 1'b0};
    end

    // Head pair is always even-aligned, so the wide word never straddles the array end
    assign dout = {mem[{rp_q[AWIDTH-2:0], 1'b1}], mem[{rp_q[AWIDTH-2:0], 1'b0}]};

    // Wrap bits are kept for pointer width consistency but flags use cnt alone
    assign unused_wrap = ^{wp_q[AWIDTH], rp_q[AWIDTH-1]};

`ifdef FIFO_ASYM_N2W_CNT_EN
    assign count       = cnt_q;
    assign almost_full = (cnt_q >= CAP - TWO);
`endif

    // Pointer and occupancy registers; reset discards any odd pending byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array, not reset
    always_ff @(posedge clk) begin
        if (we) mem[wp_q[AWIDTH-1:0]] <= din;
    end
endmodule
